// File: rtl/wb_reg_slice_pkg.sv
// Shared types and constants for the wb_reg_slice Wishbone register slice.
// The optional response timeout is enabled with WB_REG_SLICE_TIMEOUT_EN.
package wb_reg_slice_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    typedef enum logic {
        RSP_ACK = 1'b0,
        RSP_ERR = 1'b1
    } rsp_kind_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Width of the TGA/TGC/TGD tag fields carried through the slice.
    localparam int TG_WIDTH = 4;

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 bus bundle used on both sides of wb_reg_slice.
// Modports are named from the point of view of the block that owns them.
interface wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                                    CYC;
    logic                                    STB;
    logic                                    WE;
    logic [ADDR_WIDTH-1:0]                   ADR;
    logic [DATA_WIDTH-1:0]                   DAT_W;
    logic [DATA_WIDTH-1:0]                   DAT_R;
    logic [DATA_WIDTH/8-1:0]                 SEL;
    logic [wb_reg_slice_pkg::TG_WIDTH-1:0]   TGA;
    logic [wb_reg_slice_pkg::TG_WIDTH-1:0]   TGC;
    logic [wb_reg_slice_pkg::TG_WIDTH-1:0]   TGD_W;
    logic [wb_reg_slice_pkg::TG_WIDTH-1:0]   TGD_R;
    logic [2:0]                              CTI;
    logic [1:0]                              BTE;
    logic                                    ACK;
    logic                                    ERR;

    modport master (
        output CYC, STB, WE, ADR, DAT_W, SEL, TGA, TGC, TGD_W, CTI, BTE,
        input  ACK, ERR, DAT_R, TGD_R
    );

    modport slave (
        input  CYC, STB, WE, ADR, DAT_W, SEL, TGA, TGC, TGD_W, CTI, BTE,
        output ACK, ERR, DAT_R, TGD_R
    );

endinterface

// File: rtl/wb_timeout_counter.sv
// Saturating cycle counter that flags a stalled downstream access.
// Only built when WB_REG_SLICE_TIMEOUT_EN is defined; otherwise no counter exists.
`ifdef WB_REG_SLICE_TIMEOUT_EN
module wb_timeout_counter #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign expired = (cnt_q == WIDTH'(LIMIT - 1));

    // Holds at LIMIT-1 so expired stays up until the owner clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`endif

// File: rtl/wb_reg_slice.sv
// Single-outstanding Wishbone register slice: requests and responses are both registered.
// Define WB_REG_SLICE_TIMEOUT_EN to add a downstream response timeout that returns ERR.
module wb_reg_slice
    import wb_reg_slice_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic  clk,
    input logic  rstn,
    wb_if.slave  i,
    wb_if.master out
);
    localparam int SEL_WIDTH = WB_DATA_WIDTH / 8;

    state_e state_q, state_d;
    rsp_kind_e rsp_kind;
    logic rsp_seen;
    logic timeout;

    logic                     cyc_q, cyc_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_w_q, dat_w_d;
    logic [SEL_WIDTH-1:0]     sel_q, sel_d;
    logic [TG_WIDTH-1:0]      tga_q, tga_d;
    logic [TG_WIDTH-1:0]      tgc_q, tgc_d;
    logic [TG_WIDTH-1:0]      tgd_w_q, tgd_w_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [WB_DATA_WIDTH-1:0] dat_r_q, dat_r_d;
    logic [TG_WIDTH-1:0]      tgd_r_q, tgd_r_d;

    assign rsp_seen = out.ACK || out.ERR;

`ifdef WB_REG_SLICE_TIMEOUT_EN
    logic to_expired;

    wb_timeout_counter #(
        .WIDTH (16),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (state_q == IDLE),
        .en      ((state_q == REQ) && !rsp_seen),
        .expired (to_expired)
    );

    assign timeout = (state_q == REQ) && to_expired;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A master abort outranks a same-cycle downstream response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i.CYC && i.STB) state_d = REQ;
            REQ: begin
                if (!i.CYC) begin
                    state_d = IDLE;
                end else if (rsp_seen || timeout) begin
                    state_d = RSP;
                end
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_d    = (state_d == REQ);
        we_d     = we_q;
        adr_d    = adr_q;
        dat_w_d  = dat_w_q;
        sel_d    = sel_q;
        tga_d    = tga_q;
        tgc_d    = tgc_q;
        tgd_w_d  = tgd_w_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_r_d  = '0;
        tgd_r_d  = '0;
        rsp_kind = (out.ERR || !rsp_seen) ? RSP_ERR : RSP_ACK;

        if (state_q == IDLE && state_d == REQ) begin
            we_d    = i.WE;
            adr_d   = i.ADR;
            dat_w_d = i.DAT_W;
            sel_d   = i.SEL;
            tga_d   = i.TGA;
            tgc_d   = i.TGC;
            tgd_w_d = i.TGD_W;
        end

        // Response flops are non-zero only for the single RSP cycle.
        if (state_q == REQ && state_d == RSP) begin
            ack_d   = (rsp_kind == RSP_ACK);
            err_d   = (rsp_kind == RSP_ERR);
            dat_r_d = (rsp_kind == RSP_ACK) ? out.DAT_R : '0;
            tgd_r_d = rsp_seen ? out.TGD_R : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_w_q <= '0;
            sel_q   <= '0;
            tga_q   <= '0;
            tgc_q   <= '0;
            tgd_w_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= '0;
            tgd_r_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_w_q <= dat_w_d;
            sel_q   <= sel_d;
            tga_q   <= tga_d;
            tgc_q   <= tgc_d;
            tgd_w_q <= tgd_w_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_r_q <= dat_r_d;
            tgd_r_q <= tgd_r_d;
        end
    end

    assign out.CYC   = cyc_q;
    assign out.STB   = cyc_q;
    assign out.WE    = we_q;
    assign out.ADR   = adr_q;
    assign out.DAT_W = dat_w_q;
    assign out.SEL   = sel_q;
    assign out.TGA   = tga_q;
    assign out.TGC   = tgc_q;
    assign out.TGD_W = tgd_w_q;
    assign out.CTI   = CTI_CLASSIC;
    assign out.BTE   = BTE_LINEAR;

    assign i.ACK   = ack_q;
    assign i.ERR   = err_q;
    assign i.DAT_R = dat_r_q;
    assign i.TGD_R = tgd_r_q;

endmodule

// File: tb/tb_wb_reg_slice.sv
// Directed bench for wb_reg_slice: master tasks push expected responses, a monitor pops and compares.
// The timeout scenario is included only when WB_REG_SLICE_TIMEOUT_EN is defined.
module tb_wb_reg_slice;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int RW = 2 + DW + TW;
    localparam logic [TW-1:0] SLV_TGD = 4'hA;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) up_if ();
    wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn_if ();

    wb_reg_slice #(
        .WB_ADDR_WIDTH  (AW),
        .WB_DATA_WIDTH  (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .i    (up_if),
        .out  (dn_if)
    );

    // Downstream slave: mode 0 ACK, 1 ACK+ERR, 2 silent, 3 ERR; ACK comes slv_wait+1 cycles after STB.
    int          slv_wait = 0;
    int          slv_mode = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic        s_ack;
    int          s_cnt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_ack <= 1'b0;
            s_cnt <= 0;
        end else if (dn_if.CYC && dn_if.STB && !s_ack && slv_mode != 2) begin
            if (s_cnt == slv_wait) begin
                s_ack <= 1'b1;
                s_cnt <= 0;
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end else begin
            s_ack <= 1'b0;
            s_cnt <= 0;
        end
    end

    assign dn_if.ACK   = s_ack && (slv_mode == 0 || slv_mode == 1);
    assign dn_if.ERR   = s_ack && (slv_mode == 1 || slv_mode == 3);
    assign dn_if.DAT_R = slv_rdata;
    assign dn_if.TGD_R = SLV_TGD;

    logic [RW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every upstream response must match the queue head, and the next cycle must be clear.
    logic          chk_clear = 1'b0;
    logic [RW-1:0] mon_e;
    int            mon_c;

    always @(negedge clk) begin
        if (!rstn) begin
            chk_clear = 1'b0;
        end else begin
            if (chk_clear) begin
                chk("rsp_clear", {up_if.ACK, up_if.ERR, up_if.DAT_R, up_if.TGD_R}, 64'h0);
                chk_clear = 1'b0;
            end
            if (up_if.ACK || up_if.ERR) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {up_if.ACK, up_if.ERR}, 64'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_c = exp_cyc_q.pop_front();
                    chk("rsp_fields", {up_if.ACK, up_if.ERR, up_if.DAT_R, up_if.TGD_R}, mon_e);
                    chk("rsp_cycle", cyc_cnt, mon_c);
                end
                chk_clear = 1'b1;
            end
        end
    end

    task automatic idle_master();
        up_if.CYC   = 1'b0;
        up_if.STB   = 1'b0;
        up_if.WE    = 1'b0;
        up_if.ADR   = '0;
        up_if.DAT_W = '0;
        up_if.SEL   = '0;
        up_if.TGA   = '0;
        up_if.TGC   = '0;
        up_if.TGD_W = '0;
        up_if.CTI   = '0;
        up_if.BTE   = '0;
    endtask

    task automatic drive_req(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wdat,
                             input logic [2:0] cti);
        up_if.CYC   = 1'b1;
        up_if.STB   = 1'b1;
        up_if.WE    = we;
        up_if.ADR   = adr;
        up_if.DAT_W = wdat;
        up_if.SEL   = 4'hF;
        up_if.TGA   = 4'h3;
        up_if.TGC   = 4'h6;
        up_if.TGD_W = 4'h5;
        up_if.CTI   = cti;
        up_if.BTE   = 2'b01;
    endtask

    // One full access; lat is the cycle distance from request to the upstream response.
    task automatic access(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wdat,
                          input logic [2:0] cti, input logic [DW-1:0] rdat, input int wt,
                          input int mode, input logic exp_err, input logic [TW-1:0] exp_tgd,
                          input int lat);
        bit seen;
        @(negedge clk);
        slv_wait  = wt;
        slv_mode  = mode;
        slv_rdata = rdat;
        exp_q.push_back({!exp_err, exp_err, exp_err ? 32'h0 : rdat, exp_tgd});
        exp_cyc_q.push_back(cyc_cnt + lat);
        drive_req(we, adr, wdat, cti);
        @(negedge clk);
        chk("out_cyc_stb", {dn_if.CYC, dn_if.STB}, 64'h3);
        chk("out_we_adr", {dn_if.WE, dn_if.ADR}, {we, adr});
        chk("out_dat_sel", {dn_if.DAT_W, dn_if.SEL}, {wdat, 4'hF});
        chk("out_tags", {dn_if.TGA, dn_if.TGC, dn_if.TGD_W}, 12'h365);
        chk("out_cti_bte", {dn_if.CTI, dn_if.BTE}, 64'h0);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (up_if.ACK || up_if.ERR) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rsp_seen", seen, 64'h1);
        idle_master();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_master();
        #12;
        chk("rst_out_ctl", {dn_if.CYC, dn_if.STB, dn_if.WE, dn_if.CTI, dn_if.BTE}, 64'h0);
        chk("rst_out_adr_dat", {dn_if.ADR, dn_if.DAT_W}, 64'h0);
        chk("rst_out_sel_tags", {dn_if.SEL, dn_if.TGA, dn_if.TGC, dn_if.TGD_W}, 64'h0);
        chk("rst_up_rsp", {up_if.ACK, up_if.ERR, up_if.DAT_R, up_if.TGD_R}, 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Write, zero-wait slave
        access(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 3'b000, 32'h0, 0, 0, 1'b0, SLV_TGD, 3);
        // Read, two wait states
        access(1'b0, 32'h2000_0100, 32'h0, 3'b000, 32'h1234_5678, 2, 0, 1'b0, SLV_TGD, 5);
        // ACK and ERR together: ERR wins, data forced to 0
        access(1'b0, 32'h2000_0104, 32'h0, 3'b000, 32'hFFFF_0000, 0, 1, 1'b1, SLV_TGD, 3);
        // Plain ERR
        access(1'b1, 32'h3000_0000, 32'h0BAD_F00D, 3'b000, 32'h7777_7777, 1, 3, 1'b1, SLV_TGD, 4);
        // Incrementing burst serviced as classic beats, in order
        access(1'b0, 32'h4000_0000, 32'h0, 3'b010, 32'hA5A5_0001, 0, 0, 1'b0, SLV_TGD, 3);
        access(1'b0, 32'h4000_0004, 32'h0, 3'b010, 32'hA5A5_0002, 0, 0, 1'b0, SLV_TGD, 3);

        // Abort one cycle into REQ with a silent slave
        @(negedge clk);
        slv_mode = 2;
        drive_req(1'b0, 32'h5000_0000, 32'h0, 3'b000);
        @(negedge clk);
        chk("abort_stb_up", {dn_if.CYC, dn_if.STB}, 64'h3);
        idle_master();
        @(negedge clk);
        chk("abort_cyc_low", {dn_if.CYC, dn_if.STB}, 64'h0);
        repeat (4) @(negedge clk);

        // Abort on the same cycle the slave ACKs: the ACK must be discarded
        slv_mode  = 0;
        slv_wait  = 0;
        slv_rdata = 32'h9999_9999;
        drive_req(1'b0, 32'h5000_0010, 32'h0, 3'b000);
        repeat (2) @(negedge clk);
        idle_master();
        @(negedge clk);
        chk("abort_ack_cyc_low", {dn_if.CYC, dn_if.STB}, 64'h0);
        repeat (4) @(negedge clk);

        access(1'b0, 32'h5000_0020, 32'h0, 3'b000, 32'h0C0F_FEE0, 0, 0, 1'b0, SLV_TGD, 3);

        // Reset while in REQ
        @(negedge clk);
        slv_mode = 2;
        drive_req(1'b1, 32'h6000_0000, 32'h1111_2222, 3'b000);
        @(negedge clk);
        chk("rst_mid_stb_up", {dn_if.CYC, dn_if.STB}, 64'h3);
        #1 rstn = 1'b0;
        #1;
        chk("rst_mid_out", {dn_if.CYC, dn_if.STB, up_if.ACK, up_if.ERR}, 64'h0);
        chk("rst_mid_adr", dn_if.ADR, 64'h0);
        idle_master();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        access(1'b0, 32'h6000_0008, 32'h0, 3'b000, 32'h8765_4321, 1, 0, 1'b0, SLV_TGD, 4);

`ifdef WB_REG_SLICE_TIMEOUT_EN
        // Slave never answers within 8 REQ cycles: ERR with zero data and tag
        access(1'b0, 32'h7000_0000, 32'h0, 3'b000, 32'h5555_5555, 20, 0, 1'b1, 4'h0, 9);
`endif

        repeat (6) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_reg_slice.md
Name: wb_reg_slice

Overview:
- Single-outstanding Wishbone register slice that breaks the combinational path between a bus master and a downstream stage such as the address-truncation adapter or a slave.
- Every master request is registered before it is presented downstream.
- Every downstream response is registered before it is returned to the master.
- Each access goes downstream as an independent classic cycle.

Parameters:
- WB_ADDR_WIDTH, 32, address width of both interfaces.
- WB_DATA_WIDTH, 32, data width of both interfaces; SEL width is WB_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, downstream response timeout in clk cycles. Used only with WB_REG_SLICE_TIMEOUT_EN; legal range 2..65535.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rstn  input  1  reset, asynchronous assert, active-low.
- i  wb_if.slave  interface  upstream side, connected to the master.
- out  wb_if.master  interface  downstream side, connected to the slave or adapter.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rstn.
- Reset values: state IDLE. out.CYC, out.STB, out.WE, out.ADR, out.DAT_W, out.SEL, out.TGA, out.TGC, out.TGD_W, out.CTI and out.BTE are all 0. i.ACK, i.ERR, i.DAT_R and i.TGD_R are all 0.
- All out.* and i.ACK/ERR/DAT_R/TGD_R are driven from flops; nothing passes combinationally through the block.
- IDLE:
  - If i.CYC && i.STB, capture ADR, DAT_W, SEL, WE, TGA, TGC and TGD_W, go to REQ, and drive out.CYC=out.STB=1 from the next cycle.
  - out.CTI is forced to 3'b000 and out.BTE to 2'b00.
- REQ:
  - Hold all out.* stable until out.ACK or out.ERR.
  - On that cycle, capture out.DAT_R, out.TGD_R and the response kind, clear out.CYC/STB, and go to RSP.
  - If ACK and ERR are asserted together, ERR wins.
- RSP:
  - Assert exactly one of i.ACK or i.ERR for exactly 1 cycle, with i.DAT_R/i.TGD_R valid in that cycle, then go to IDLE.
  - i.STB is not sampled in RSP, so the stale request is never re-issued.
- Clearing: i.DAT_R and i.TGD_R return to 0 when i.ACK/ERR deassert. On ERR, i.DAT_R is 0.
- Latency:
  - 1 cycle from a request in IDLE to out.STB.
  - 1 cycle from out.ACK to i.ACK.
  - Zero-wait slave: i.STB seen at cycle N gives i.ACK at cycle N+3.
  - Back-to-back throughput is 1 access per 4 cycles with a zero-wait slave.
- Master abort (i.CYC low while in REQ):
  - out.CYC/STB deassert on the next cycle, return to IDLE, no response is returned.
  - A downstream ACK/ERR in the abort cycle is discarded.
- Burst requests (CTI 3'b001/010) are accepted and serviced as individual classic beats. The master receives one ACK per beat, in order.
- Reset mid-transaction: all outputs return to their reset values immediately and the FSM goes to IDLE. Any in-flight response is lost.
- Exactly one transaction is in flight at any time.

Optional Feature:
- Macro: WB_REG_SLICE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ACK/ERR.
  - When it reaches TIMEOUT_CYCLES-1, drop out.CYC/STB next cycle, go to RSP, and return i.ERR with i.DAT_R=0.
  - A slave ACK arriving on the same edge as the timeout wins and is returned as a normal ACK.
  - A late slave response after the timeout is ignored.
- Undefined: no counter logic is present; REQ waits indefinitely.

Decomposition:
- wb_reg_slice_pkg holds:
  - state enum typedef (IDLE, REQ, RSP);
  - CTI constants (CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_EOB=3'b111);
  - BTE_LINEAR=2'b00;
  - response-kind typedef (RSP_ACK, RSP_ERR).
- Sub-module wb_timeout_counter (params WIDTH, LIMIT; ports clk, rstn, clr, en, expired), instantiated only under WB_REG_SLICE_TIMEOUT_EN.

Test Plan:
- Write: ADR=0x1000_0040, DAT_W=0xDEAD_BEEF, SEL=4'hF, zero-wait slave -> out.STB 1 cycle after i.STB with identical ADR/DAT/SEL/WE=1; i.ACK 3 cycles after i.STB, 1 cycle wide.
- Read with 2-wait-state slave returning 0x1234_5678 -> i.ACK at +5 cycles with i.DAT_R=0x1234_5678; i.DAT_R=0 in the following cycle.
- Slave asserts ACK and ERR together -> i.ERR=1, i.ACK=0, i.DAT_R=0.
- Master drops CYC 1 cycle into REQ with slave silent -> out.CYC low next cycle; no i.ACK/ERR; next request is serviced normally.
- rstn pulsed low while in REQ -> out.CYC/STB and i.ACK immediately 0; after release, a new read completes correctly.
- With WB_REG_SLICE_TIMEOUT_EN and TIMEOUT_CYCLES=8, a never-responding slave -> out.STB drops after 8 REQ cycles; i.ERR pulses 1 cycle; a later slave ACK is ignored.
